// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and the pending-owner encoding for the
// two-requester main-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Who owns the access issued on the previous edge.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IREAD  = 2'd1,
    OWN_DREAD  = 2'd2,
    OWN_DWRITE = 2'd3
  } mem_owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: per-cycle grant between the fetch and data requesters.
// The data port wins unless fetch has been denied STARVE_LIMIT cycles in a row.
//   clock    in  rising-edge clock
//   reset_n  in  synchronous active-low reset (forces both grants low)
//   IReq     in  fetch request
//   DReq     in  data request
//   IReady   out fetch granted this cycle
//   DReady   out data granted this cycle
module mem_arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic IReq,
  input  logic DReq,
  output logic IReady,
  output logic DReady
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt;

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    if (cnt >= LIMIT) return LIMIT;
    return cnt + 3'd1;
  endfunction

  always_comb begin
    DReady = reset_n && DReq && (starve_cnt < LIMIT);
    IReady = reset_n && IReq && !DReady;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      starve_cnt <= 3'd0;
    else if (!IReq || IReady)
      starve_cnt <= 3'd0;
    else
      starve_cnt <= sat_inc(starve_cnt);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction fetch and load/store onto the single
// registered-read main-memory port and routes the one-cycle-later response
// (read data, store acknowledge, range error) back to its owner.
//   clock, reset_n                      clock / synchronous active-low reset
//   IReq, IAddr -> IReady, IValid, IData fetch port
//   DReq, DWrite, DAddr, DWdata ->
//     DReady, DValid, DRdata, DErr      load/store port
//   MemAddress, MemDataIn, MemWrite,
//   MemVal                              memory port (MemVal one cycle late)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH    = 4097,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IReady,
  output logic              IValid,
  output logic [DATA_W-1:0] IData,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DReady,
  output logic              DValid,
  output logic [DATA_W-1:0] DRdata,
  output logic              DErr,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemVal
);

  logic       i_oor, d_oor;
  mem_owner_t owner_p0, pend_owner_p1;
  logic       err_p0, pend_err_p1;
  logic       i_vld_p1, d_vld_p1;
  logic [DATA_W-1:0] i_val_p1, d_val_p1;
  logic [DATA_W-1:0] i_held, d_held;

  mem_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clock  (clock),
    .reset_n(reset_n),
    .IReq   (IReq),
    .DReq   (DReq),
    .IReady (IReady),
    .DReady (DReady)
  );

  assign i_oor = 32'(IAddr) >= 32'(MEM_DEPTH);
  assign d_oor = 32'(DAddr) >= 32'(MEM_DEPTH);

  // ---- stage p0: accepted request drives the memory port ----
  // Out-of-range accesses never reach memory: address parked at 0, no write.
  always_comb begin
    MemAddress = '0;
    MemDataIn  = '0;
    MemWrite   = 1'b0;
    owner_p0   = OWN_NONE;
    err_p0     = 1'b0;
    if (DReady) begin
      owner_p0  = DWrite ? OWN_DWRITE : OWN_DREAD;
      err_p0    = d_oor;
      MemDataIn = DWdata;
      if (!d_oor) begin
        MemAddress = DAddr;
        MemWrite   = DWrite;
      end
    end else if (IReady) begin
      owner_p0 = OWN_IREAD;
      err_p0   = i_oor;
      if (!i_oor) MemAddress = IAddr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_owner_p1 <= OWN_NONE;
      pend_err_p1   <= 1'b0;
    end else begin
      pend_owner_p1 <= owner_p0;
      pend_err_p1   <= err_p0;
    end
  end

  // ---- stage p1: memory data returns, route it to the owner ----
  // Valid is gated by reset_n so a read in flight at reset never surfaces.
  always_comb begin
    i_vld_p1 = reset_n && (pend_owner_p1 == OWN_IREAD);
    d_vld_p1 = reset_n && ((pend_owner_p1 == OWN_DREAD) || (pend_owner_p1 == OWN_DWRITE));
    i_val_p1 = pend_err_p1 ? '0 : MemVal;
    if (pend_err_p1)                      d_val_p1 = '0;
    else if (pend_owner_p1 == OWN_DREAD)  d_val_p1 = MemVal;
    else                                  d_val_p1 = d_held;

    IValid = i_vld_p1;
    IData  = i_vld_p1 ? i_val_p1 : i_held;
    DValid = d_vld_p1;
    DRdata = d_vld_p1 ? d_val_p1 : d_held;
    DErr   = d_vld_p1 && pend_err_p1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      i_held <= '0;
      d_held <= '0;
    end else begin
      if (i_vld_p1) i_held <= i_val_p1;
      if (d_vld_p1) d_held <= d_val_p1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int DEPTH = 4097;
  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        IReq, DReq, DWrite;
  logic [15:0] IAddr, DAddr, DWdata;
  logic        IReady, IValid, DReady, DValid, DErr, MemWrite;
  logic [15:0] IData, DRdata, MemAddress, MemDataIn, MemVal;

  logic        fill = 1'b0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [15:0] pre_data = 16'h0;
  logic [15:0] mem [0:DEPTH-1];
  logic [15:0] ref_mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IValid(IValid), .IData(IData),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWdata(DWdata),
    .DReady(DReady), .DValid(DValid), .DRdata(DRdata), .DErr(DErr),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemWrite(MemWrite), .MemVal(MemVal)
  );

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Main memory: registered read, write at the end of the cycle.
  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (MemWrite && (32'(MemAddress) < DEPTH)) begin
      mem[MemAddress] <= MemDataIn;
    end
    MemVal <= (32'(MemAddress) < DEPTH) ? mem[MemAddress] : 16'h0;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic to_drive();
    @(posedge clock);
    #1;
  endtask

  task automatic to_check();
    #3;
  endtask

  task automatic idle();
    IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
    IAddr = 16'h0; DAddr = 16'h0; DWdata = 16'h0;
  endtask

  typedef struct {
    logic ireq, dreq, dwrite;
    logic [15:0] iaddr, daddr, wdata;
    logic exp_ir, exp_dr;
    logic [15:0] exp_ma;
    logic exp_mw, exp_iv, exp_dv, exp_de;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'h1000;
      1:       return 16'h1001;
      2:       return 16'($urandom);
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  // Reference model state (abstract: expected response of the previous accept)
  int          m_wait;
  int          r_kind;   // 0 none, 1 fetch read, 2 load, 3 store
  logic        r_err;
  logic [15:0] r_data, held_i, held_d;

  initial begin
    tbl[0] = '{1'b1,1'b0,1'b0,16'h0002,16'h0000,16'h0000, 1'b1,1'b0,16'h0002,1'b0, 1'b1,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1,1'b1,16'h0000,16'h0020,16'h55AA, 1'b0,1'b1,16'h0020,1'b1, 1'b0,1'b1,1'b0};
    tbl[2] = '{1'b1,1'b1,1'b0,16'h0005,16'h0030,16'h0000, 1'b0,1'b1,16'h0030,1'b0, 1'b0,1'b1,1'b0};
    tbl[3] = '{1'b0,1'b1,1'b1,16'h0000,16'h1001,16'h1111, 1'b0,1'b1,16'h0000,1'b0, 1'b0,1'b1,1'b1};
    tbl[4] = '{1'b0,1'b1,1'b0,16'h0000,16'h1000,16'h0000, 1'b0,1'b1,16'h1000,1'b0, 1'b0,1'b1,1'b0};
    tbl[5] = '{1'b1,1'b0,1'b0,16'h1001,16'h0000,16'h0000, 1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0};
    tbl[6] = '{1'b0,1'b0,1'b1,16'h0007,16'h0009,16'h0001, 1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b0};
    tbl[7] = '{1'b0,1'b1,1'b0,16'h0000,16'hFFFF,16'h0000, 1'b0,1'b1,16'h0000,1'b0, 1'b0,1'b1,1'b1};

    // Memory setup while in reset
    reset_n = 1'b0;
    idle();
    fill = 1'b1;
    to_drive();
    fill = 1'b0;
    pre_we = 1'b1; pre_addr = 16'h0002; pre_data = 16'h1234;
    to_drive();
    pre_we = 1'b0;

    // Reset with both requests held: nothing granted, nothing written
    IReq = 1'b1; IAddr = 16'h0003;
    DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h0040; DWdata = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      to_check();
      chk1("rst_iready", IReady, 1'b0);
      chk1("rst_dready", DReady, 1'b0);
      chk1("rst_memwrite", MemWrite, 1'b0);
      chk1("rst_ivalid", IValid, 1'b0);
      chk1("rst_dvalid", DValid, 1'b0);
      to_drive();
    end
    reset_n = 1'b1;
    to_check();
    chk1("rel_dready", DReady, 1'b1);
    chk1("rel_iready", IReady, 1'b0);
    chk1("rel_memwrite", MemWrite, 1'b1);
    chk16("rel_memaddr", MemAddress, 16'h0040);
    chk1("rel_no_stale_ivalid", IValid, 1'b0);
    chk1("rel_no_stale_dvalid", DValid, 1'b0);
    to_drive();
    DReq = 1'b0;
    to_check();
    chk1("rel_store_ack", DValid, 1'b1);
    chk1("rel_fetch_grant", IReady, 1'b1);
    to_drive();
    idle();
    to_check();
    chk1("rel_fetch_valid", IValid, 1'b1);
    chk16("rel_fetch_data", IData, pat(3));
    to_drive();

    // Store then load of the same address in back-to-back cycles
    DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h0010; DWdata = 16'hBEEF;
    to_check();
    chk1("st_dready", DReady, 1'b1);
    chk1("st_memwrite", MemWrite, 1'b1);
    chk16("st_memaddr", MemAddress, 16'h0010);
    chk16("st_memdata", MemDataIn, 16'hBEEF);
    to_drive();
    DWrite = 1'b0;
    to_check();
    chk1("st_ack", DValid, 1'b1);
    chk1("st_ack_derr", DErr, 1'b0);
    chk1("ld_dready", DReady, 1'b1);
    chk1("ld_memwrite", MemWrite, 1'b0);
    to_drive();
    idle();
    to_check();
    chk1("ld_dvalid", DValid, 1'b1);
    chk16("ld_drdata", DRdata, 16'hBEEF);
    chk1("ld_derr", DErr, 1'b0);
    to_drive();
    to_check();
    chk1("ld_dvalid_low", DValid, 1'b0);
    chk16("ld_drdata_held", DRdata, 16'hBEEF);
    to_drive();

    // Lone fetch of preloaded word
    IReq = 1'b1; IAddr = 16'h0002;
    to_check();
    chk1("f_iready", IReady, 1'b1);
    chk16("f_memaddr", MemAddress, 16'h0002);
    to_drive();
    idle();
    to_check();
    chk1("f_ivalid", IValid, 1'b1);
    chk16("f_idata", IData, 16'h1234);
    to_drive();
    to_check();
    chk1("f_ivalid_low", IValid, 1'b0);
    chk16("f_idata_held", IData, 16'h1234);
    to_drive();

    // Contention: four data grants then one fetch, repeating
    IReq = 1'b1; IAddr = 16'h0002;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      to_check();
      chk1($sformatf("starve_iready_%0d", k), IReady, (k % 5) == 4);
      chk1($sformatf("starve_dready_%0d", k), DReady, (k % 5) != 4);
      to_drive();
    end
    idle();
    to_check();
    chk1("starve_last_ivalid", IValid, 1'b1);
    chk16("starve_last_idata", IData, 16'h1234);
    to_drive();

    // Out-of-range store and load
    DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h1001; DWdata = 16'hAAAA;
    to_check();
    chk1("oor_st_dready", DReady, 1'b1);
    chk1("oor_st_memwrite", MemWrite, 1'b0);
    to_drive();
    idle();
    to_check();
    chk1("oor_st_dvalid", DValid, 1'b1);
    chk1("oor_st_derr", DErr, 1'b1);
    to_drive();
    DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h1001;
    to_check();
    chk1("oor_ld_dready", DReady, 1'b1);
    chk16("oor_ld_memaddr", MemAddress, 16'h0000);
    to_drive();
    idle();
    to_check();
    chk1("oor_ld_dvalid", DValid, 1'b1);
    chk1("oor_ld_derr", DErr, 1'b1);
    chk16("oor_ld_drdata", DRdata, 16'h0000);
    to_drive();

    // Single-cycle grant / range vectors, each followed by an idle cycle
    for (int v = 0; v < 8; v++) begin
      IReq = tbl[v].ireq; DReq = tbl[v].dreq; DWrite = tbl[v].dwrite;
      IAddr = tbl[v].iaddr; DAddr = tbl[v].daddr; DWdata = tbl[v].wdata;
      to_check();
      chk1($sformatf("vec%0d_iready", v), IReady, tbl[v].exp_ir);
      chk1($sformatf("vec%0d_dready", v), DReady, tbl[v].exp_dr);
      chk16($sformatf("vec%0d_memaddr", v), MemAddress, tbl[v].exp_ma);
      chk1($sformatf("vec%0d_memwrite", v), MemWrite, tbl[v].exp_mw);
      to_drive();
      idle();
      to_check();
      chk1($sformatf("vec%0d_ivalid", v), IValid, tbl[v].exp_iv);
      chk1($sformatf("vec%0d_dvalid", v), DValid, tbl[v].exp_dv);
      chk1($sformatf("vec%0d_derr", v), DErr, tbl[v].exp_de);
      to_drive();
    end

    // Load in flight when reset hits: dropped, held data cleared
    DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0010;
    to_check();
    chk1("rf_first_dready", DReady, 1'b1);
    to_drive();
    to_check();
    chk1("rf_first_dvalid", DValid, 1'b1);
    chk16("rf_first_drdata", DRdata, 16'hBEEF);
    chk1("rf_second_dready", DReady, 1'b1);
    to_drive();
    idle();
    reset_n = 1'b0;
    to_check();
    chk1("rf_inflight_dvalid", DValid, 1'b0);
    to_drive();
    to_check();
    chk1("rf_after_dvalid", DValid, 1'b0);
    chk16("rf_after_drdata", DRdata, 16'h0000);
    chk16("rf_after_idata", IData, 16'h0000);
    to_drive();
    reset_n = 1'b1;
    to_check();
    chk1("rf_release_dvalid", DValid, 1'b0);
    chk1("rf_release_ivalid", IValid, 1'b0);
    to_drive();

    // Randomized traffic against the reference model
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    m_wait = 0; r_kind = 0; r_err = 1'b0; r_data = 16'h0; held_i = 16'h0; held_d = 16'h0;
    begin
      logic i_acc, d_acc;
      i_acc = 1'b0; d_acc = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic exp_ir, exp_dr, exp_mw, ev_i, ev_d, i_oor, d_oor;
        logic [15:0] exp_ma, exp_id, exp_dd;
        // requester agents: hold until accepted, then maybe issue a new one
        if (i_acc) IReq = 1'b0;
        if (d_acc) DReq = 1'b0;
        if (!IReq && ($urandom_range(0, 2) == 0)) begin
          IReq = 1'b1; IAddr = rand_addr();
        end
        if (!DReq && ($urandom_range(0, 1) == 0)) begin
          DReq = 1'b1; DWrite = 1'($urandom_range(0, 1));
          DAddr = rand_addr(); DWdata = 16'($urandom);
        end
        reset_n = (cyc == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);

        i_oor = 32'(IAddr) >= DEPTH;
        d_oor = 32'(DAddr) >= DEPTH;
        exp_dr = reset_n && DReq && (m_wait < LIMIT);
        exp_ir = reset_n && IReq && !exp_dr;
        exp_mw = exp_dr && DWrite && !d_oor;
        exp_ma = exp_dr ? (d_oor ? 16'h0 : DAddr) : (exp_ir ? (i_oor ? 16'h0 : IAddr) : 16'h0);
        ev_i = reset_n && (r_kind == 1);
        ev_d = reset_n && (r_kind >= 2);
        exp_id = ev_i ? (r_err ? 16'h0 : r_data) : held_i;
        exp_dd = ev_d ? (r_err ? 16'h0 : ((r_kind == 2) ? r_data : held_d)) : held_d;

        to_check();
        chk1("rnd_iready", IReady, exp_ir);
        chk1("rnd_dready", DReady, exp_dr);
        chk1("rnd_memwrite", MemWrite, exp_mw);
        chk16("rnd_memaddr", MemAddress, exp_ma);
        chk1("rnd_ivalid", IValid, ev_i);
        chk16("rnd_idata", IData, exp_id);
        chk1("rnd_dvalid", DValid, ev_d);
        chk16("rnd_drdata", DRdata, exp_dd);
        chk1("rnd_derr", DErr, ev_d && r_err);
        i_acc = IReady;
        d_acc = DReady;

        if (!reset_n) begin
          m_wait = 0; r_kind = 0; r_err = 1'b0; held_i = 16'h0; held_d = 16'h0;
        end else begin
          if (ev_i) held_i = exp_id;
          if (ev_d) held_d = exp_dd;
          m_wait = (IReq && !exp_ir) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
          if (exp_dr) begin
            r_kind = DWrite ? 3 : 2;
            r_err  = d_oor;
            r_data = d_oor ? 16'h0 : ref_mem[int'(DAddr)];
            if (DWrite && !d_oor) ref_mem[int'(DAddr)] = DWdata;
          end else if (exp_ir) begin
            r_kind = 1;
            r_err  = i_oor;
            r_data = i_oor ? 16'h0 : ref_mem[int'(IAddr)];
          end else begin
            r_kind = 0;
            r_err  = 1'b0;
          end
        end
        to_drive();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sitting directly upstream of the 16-bit unified main memory. Merges the instruction-fetch port and the load/store data port onto the single memory port (Address, DataIn, MemWrite, MemVal), tracks the one outstanding read, and returns read data and write acknowledges to the correct requester. Data port has priority; a starvation counter guarantees fetch progress.

## Interface
- MEM_DEPTH, 4097: number of valid word addresses (0..MEM_DEPTH-1).
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch wins.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.
- IReq  in  1  fetch request; held with IAddr stable until IReady.
- IAddr  in  16  fetch word address.
- IReady  out  1  fetch request accepted this cycle.
- IValid  out  1  fetch data valid pulse.
- IData  out  16  fetch data.
- DReq  in  1  data request; held with DWrite/DAddr/DWdata stable until DReady.
- DWrite  in  1  1 = store, 0 = load.
- DAddr  in  16  data word address.
- DWdata  in  16  store data.
- DReady  out  1  data request accepted this cycle.
- DValid  out  1  load data valid, or store acknowledge.
- DRdata  out  16  load data.
- DErr  out  1  with DValid: address out of range.
- MemAddress  out  16  to memory Address.
- MemDataIn  out  16  to memory DataIn.
- MemWrite  out  1  to memory MemWrite.
- MemVal  in  16  from memory; registered read, valid the cycle after the address edge.

## Operation
- Grant, combinational per cycle, at most one of IReady/DReady high:
  - DReq=1 and starve count < STARVE_LIMIT: DReady=1.
  - else IReq=1: IReady=1.
- Starve counter (3 bits): +1 each cycle IReq=1 and IReady=0, saturating at STARVE_LIMIT; cleared when IReq=0 or IReady=1.
- Accepted request drives memory in the same cycle: MemAddress = granted address, MemDataIn = DWdata, MemWrite = DWrite on a data grant, else 0.
- No grant: MemAddress=0, MemWrite=0, MemDataIn=0. The resulting idle read is ignored.
- Range check: address >= MEM_DEPTH. Out-of-range store drives MemWrite=0. Out-of-range load or fetch is not forwarded: MemAddress=0.
- Pending register: owner {NONE, IREAD, DREAD, DWRITE} plus error bit, loaded on every edge from the current grant.
- Cycle after accept:
  - IREAD: IValid=1, IData=MemVal.
  - DREAD: DValid=1, DRdata=MemVal.
  - DWRITE: DValid=1, DRdata held.
  - Error bit set: DValid=1, DErr=1, DRdata=0. An out-of-range fetch gives IValid=1, IData=0.
- Held registers keep the last delivered IData/DRdata while Valid=0.

## Timing
- Read latency 1: accept in cycle N, Valid and data in N+1.
- Throughput 1 access/cycle. A new accept in N+1 is allowed alongside N's Valid.
- A store is written at the end of cycle N. A load of the same address accepted in N+1 returns the new data in N+2.
- Reset (reset_n=0 at an edge):
  - Pending <- NONE, starve count <- 0, held IData/DRdata <- 0.
  - While reset_n=0: IReady=DReady=0, MemWrite=0.
  - Reads in flight are dropped; no Valid follows reset.
- Simultaneous IReq and DReq with count < STARVE_LIMIT: data first, fetch stalls.
- Count reaching STARVE_LIMIT with both pending: fetch granted that cycle, count cleared.
- Requester drops Req before Ready: protocol violation, undefined.

## Structure
- Package mem_arb_pkg:
  - ADDR_W=16, DATA_W=16.
  - Owner enum typedef mem_owner_t {OWN_NONE, OWN_IREAD, OWN_DREAD, OWN_DWRITE}.
- Sub-module mem_arb_grant: grant logic plus starve counter. Outputs IReady/DReady; counter state internal.
- Top level holds the pending register, range check, memory-port mux and return-path registers.

## Test plan
- Reset with IReq=DReq=1 held: IReady=DReady=MemWrite=0. First cycle after release grants DReady=1, no stale Valid.
- Store 16'hBEEF to 16'h0010, then load 16'h0010 next cycle: DValid ack, then DValid with DRdata=16'hBEEF, DErr=0.
- Fetch alone at 16'h0002 preloaded 16'h1234: IReady in N; IValid, IData=16'h1234 in N+1; IData holds afterwards.
- IReq and DReq both held for 10 cycles: DReady for 4 cycles, IReady on cycle 5, then data resumes. Repeats; no fetch waits more than 4 cycles.
- Store to 16'h1001 (4097): MemWrite=0, DValid=1, DErr=1; a later load of 16'h1001 returns 0 with DErr=1.
- Load accepted in N, reset_n=0 in N+1: no DValid, DRdata=0, pending owner NONE.
